// File: rtl/mdu_pkg.sv
// ============================================================================
// Module  : mdu_pkg
// Brief   : Shared operation codes, FSM states and width constants for the MDU.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

   localparam int c_XLEN  = 32;
   localparam int c_CNT_W = $clog2(c_XLEN);

   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6
   } mdu_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_if.sv
// ============================================================================
// Module  : mdu_if
// Brief   : E-stage to MDU request/response bundle (master = pipeline side).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mdu_if import mdu_pkg::*; #(
   parameter int XLEN = c_XLEN
) ();

   logic            start;
   mdu_op_t         op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            e_stall;
   logic            flush;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (output start, op, a, b, e_stall, flush, input done, hi, lo);
   modport slave  (input start, op, a, b, e_stall, flush, output done, hi, lo);

endinterface

`default_nettype wire

// File: rtl/mdu_divider.sv
// ============================================================================
// Module  : mdu_divider
// Brief   : Iterative restoring unsigned divider, one quotient bit per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_divider import mdu_pkg::*; #(
   parameter int XLEN = c_XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_dvs;
   logic [XLEN:0]   w_shift;
   logic [XLEN:0]   w_diff;
   logic            w_fits;

   // Outputs show the state after the step in progress, so the owner can
   // capture the final result on the same edge that completes the last step.
   always_comb begin
      w_shift   = {r_rem, r_quo[XLEN-1]};
      w_diff    = w_shift - {1'b0, r_dvs};
      w_fits    = ~w_diff[XLEN];
      quotient  = {r_quo[XLEN-2:0], w_fits};
      remainder = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_quo <= '0;
         r_rem <= '0;
         r_dvs <= '0;
      end else if (load) begin
         r_quo <= dividend;
         r_rem <= '0;
         r_dvs <= divisor;
      end else begin
         r_quo <= quotient;
         r_rem <= remainder;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mdu.sv
// ============================================================================
// Module  : mdu
// Brief   : Multi-cycle multiply/divide unit with HI/LO commit gated by E retire.
//           MDU_FAST_MULT_EN selects a single-stage registered multiplier.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu import mdu_pkg::*; #(
   parameter int XLEN = c_XLEN
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus
);

   localparam int                c_CW   = (XLEN == c_XLEN) ? c_CNT_W : $clog2(XLEN);
   localparam logic [c_CW-1:0]   c_LAST = c_CW'(XLEN - 1);

   mdu_state_t        r_state;
   logic [c_CW-1:0]   r_count;
   logic [XLEN-1:0]   r_mcand;
   logic [2*XLEN-1:0] r_prod;
   logic [XLEN-1:0]   r_resHi;
   logic [XLEN-1:0]   r_resLo;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic              r_isDiv;
   logic              r_resNeg;
   logic              r_remNeg;
   logic              r_divZero;

   logic              w_isSigned;
   logic              w_isMulDiv;
   logic              w_accept;
   logic              w_last;
   logic              w_done;
   logic [XLEN-1:0]   w_absA;
   logic [XLEN-1:0]   w_absB;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_quoFix;
   logic [XLEN-1:0]   w_remFix;
   logic [2*XLEN-1:0] w_prodNext;
   logic [2*XLEN-1:0] w_prodFix;

   always_comb begin
      w_isSigned = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
      w_isMulDiv = bus.op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
      w_accept   = (r_state == S_IDLE) && bus.start && w_isMulDiv && !bus.flush;
      w_absA     = (w_isSigned && bus.a[XLEN-1]) ? -bus.a : bus.a;
      w_absB     = (w_isSigned && bus.b[XLEN-1]) ? -bus.b : bus.b;
   end

`ifdef MDU_FAST_MULT_EN
   always_comb begin
      w_prodNext = {{XLEN{1'b0}}, r_mcand} * {{XLEN{1'b0}}, r_prod[XLEN-1:0]};
      w_last     = r_isDiv ? (r_count == c_LAST) : 1'b1;
   end
`else
   logic [XLEN:0] w_sum;

   // Shift-add: accumulate into the upper half, multiplier drains from the LSB.
   always_comb begin
      w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
      w_prodNext = {w_sum, r_prod[XLEN-1:1]};
      w_last     = (r_count == c_LAST);
   end
`endif

   mdu_divider #(.XLEN(XLEN)) u_divider (
      .clk       (clk),
      .reset     (reset),
      .load      (w_accept),
      .dividend  (w_absA),
      .divisor   (w_absB),
      .quotient  (w_quo),
      .remainder (w_rem)
   );

   // Divide-by-zero yields all-ones regardless of the dividend sign.
   always_comb begin
      w_prodFix = r_resNeg ? -w_prodNext : w_prodNext;
      w_quoFix  = r_divZero ? '1 : (r_resNeg ? -w_quo : w_quo);
      w_remFix  = r_remNeg ? -w_rem : w_rem;
   end

   always_comb begin
      w_done = 1'b1;
      if (!bus.flush) begin
         case (r_state)
            S_IDLE:  w_done = !(bus.start && w_isMulDiv);
            S_BUSY:  w_done = 1'b0;
            default: w_done = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_mcand   <= '0;
         r_prod    <= '0;
         r_resHi   <= '0;
         r_resLo   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_isDiv   <= 1'b0;
         r_resNeg  <= 1'b0;
         r_remNeg  <= 1'b0;
         r_divZero <= 1'b0;
      end else if (bus.flush) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mcand   <= w_absA;
                  r_prod    <= {{XLEN{1'b0}}, w_absB};
                  r_isDiv   <= (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
                  r_resNeg  <= w_isSigned && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                  r_remNeg  <= w_isSigned && bus.a[XLEN-1];
                  r_divZero <= (bus.b == '0);
                  r_count   <= '0;
                  r_state   <= S_BUSY;
               end else if (bus.start && !bus.e_stall) begin
                  if (bus.op == MDU_MTHI) r_hi <= bus.a;
                  if (bus.op == MDU_MTLO) r_lo <= bus.a;
               end
            end
            S_BUSY: begin
               r_count <= r_count + 1'b1;
               if (!r_isDiv) r_prod <= w_prodNext;
               if (w_last) begin
                  r_resHi <= r_isDiv ? w_remFix : w_prodFix[2*XLEN-1:XLEN];
                  r_resLo <= r_isDiv ? w_quoFix : w_prodFix[XLEN-1:0];
                  r_count <= '0;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (!bus.e_stall) begin
                  r_hi    <= r_resHi;
                  r_lo    <= r_resLo;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.done = w_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// ============================================================================
// Module  : tb_mdu
// Brief   : Self-checking bench for mdu: directed vectors, corner sequences and
//           randomized operations against an arithmetic reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mdu;
   import mdu_pkg::*;

   localparam int XLEN = 32;
`ifdef MDU_FAST_MULT_EN
   localparam int c_MUL_LOW  = 2;
   localparam int c_FLUSH_AT = 1;
`else
   localparam int c_MUL_LOW  = XLEN + 1;
   localparam int c_FLUSH_AT = 11;
`endif
   localparam int c_DIV_LOW = XLEN + 1;

   logic clk = 1'b0;
   logic reset;

   mdu_if #(.XLEN(XLEN)) bus ();
   mdu #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int nChecks = 0;
   int nErrors = 0;
   logic [31:0] mHi = '0;
   logic [31:0] mLo = '0;

   typedef struct {
      mdu_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          low;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int expLow(input mdu_op_t op);
      if (op == MDU_MULT || op == MDU_MULTU) return c_MUL_LOW;
      if (op == MDU_DIV || op == MDU_DIVU) return c_DIV_LOW;
      return 0;
   endfunction

   task automatic modelApply(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
      longint      sp;
      logic [63:0] up;
      int          sa, sb;
      sa = a;
      sb = b;
      case (op)
         MDU_MULT: begin
            sp = longint'(sa) * longint'(sb);
            {mHi, mLo} = sp;
         end
         MDU_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            {mHi, mLo} = up;
         end
         MDU_DIV: begin
            if (b == 0) begin mLo = '1; mHi = a; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin mLo = a; mHi = 0; end
            else begin mLo = sa / sb; mHi = sa % sb; end
         end
         MDU_DIVU: begin
            if (b == 0) begin mLo = '1; mHi = a; end
            else begin mLo = a / b; mHi = a % b; end
         end
         MDU_MTHI: mHi = a;
         MDU_MTLO: mLo = a;
         default: ;
      endcase
   endtask

   // Issue one instruction, hold it while done=0, retire it, return HI/LO.
   task automatic runOp(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output int low, output logic [31:0] rHi, output logic [31:0] rLo);
      int guard;
      guard = 0;
      low   = 0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      bus.e_stall = 1'b0; bus.flush = 1'b0;
      #1;
      while (bus.done == 1'b0 && guard < 200) begin
         low++; guard++;
         @(posedge clk); #2;
      end
      if (guard >= 200) check("timeout_done", 64'(guard), 64'(0));
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op = MDU_NONE;
      #1;
      rHi = bus.hi;
      rLo = bus.lo;
   endtask

   vec_t vecs[12];
   int          low;
   logic [31:0] gHi, gLo;

   initial begin
      vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, c_MUL_LOW};
      vecs[1]  = '{MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        c_DIV_LOW};
      vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, c_DIV_LOW};
      vecs[3]  = '{MDU_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, c_DIV_LOW};
      vecs[4]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, c_DIV_LOW};
      vecs[5]  = '{MDU_MTHI,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'h8000_0000, 0};
      vecs[6]  = '{MDU_MTLO,  32'hDEAD_BEEF, 32'd0,         32'h0000_1234, 32'hDEAD_BEEF, 0};
      vecs[7]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, c_MUL_LOW};
      vecs[8]  = '{MDU_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, c_DIV_LOW};
      vecs[9]  = '{MDU_MULT,  32'd6,         32'd7,         32'd0,         32'd42,        c_MUL_LOW};
      vecs[10] = '{MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, c_DIV_LOW};
      vecs[11] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, c_DIV_LOW};

      bus.start = 1'b0; bus.op = MDU_NONE; bus.a = '0; bus.b = '0;
      bus.e_stall = 1'b0; bus.flush = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("reset_done", 64'(bus.done), 64'(1));
      check("reset_hi", 64'(bus.hi), 64'(0));
      check("reset_lo", 64'(bus.lo), 64'(0));

      for (int i = 0; i < 12; i++) begin
         runOp(vecs[i].op, vecs[i].a, vecs[i].b, low, gHi, gLo);
         check($sformatf("vec%0d_low", i), 64'(low), 64'(vecs[i].low));
         check($sformatf("vec%0d_hi", i), 64'(gHi), 64'(vecs[i].hi));
         check($sformatf("vec%0d_lo", i), 64'(gLo), 64'(vecs[i].lo));
         mHi = vecs[i].hi;
         mLo = vecs[i].lo;
      end

      // No-op and gated MTHI/MTLO must leave HI/LO alone.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = MDU_NONE; bus.a = 32'h5555_5555;
      #1 check("none_done", 64'(bus.done), 64'(1));
      @(posedge clk); #1;
      bus.op = MDU_MTHI; bus.e_stall = 1'b1;
      #1 check("mthi_stall_done", 64'(bus.done), 64'(1));
      @(posedge clk); #1;
      bus.op = MDU_MTLO; bus.e_stall = 1'b0; bus.flush = 1'b1;
      #1 check("mtlo_flush_done", 64'(bus.done), 64'(1));
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = MDU_NONE;
      #1;
      check("gated_hi", 64'(bus.hi), 64'(mHi));
      check("gated_lo", 64'(bus.lo), 64'(mLo));

      // Flush together with a start: nothing is accepted.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = MDU_DIV; bus.a = 32'd9; bus.b = 32'd2; bus.flush = 1'b1;
      #1 check("flush_start_done", 64'(bus.done), 64'(1));
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = MDU_NONE;
      #1 check("flush_start_idle", 64'(bus.done), 64'(1));

      // Flush in the middle of a multiply.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = MDU_MULTU; bus.a = 32'd3; bus.b = 32'd4;
      repeat (c_FLUSH_AT) @(posedge clk);
      #1;
      check("pre_flush_busy", 64'(bus.done), 64'(0));
      bus.start = 1'b0; bus.op = MDU_NONE; bus.flush = 1'b1;
      #1 check("flush_done", 64'(bus.done), 64'(1));
      @(posedge clk); #1;
      bus.flush = 1'b0;
      #1;
      check("flush_hi", 64'(bus.hi), 64'(mHi));
      check("flush_lo", 64'(bus.lo), 64'(mLo));
      runOp(MDU_MULTU, 32'd3, 32'd4, low, gHi, gLo);
      check("after_flush_low", 64'(low), 64'(c_MUL_LOW));
      check("after_flush_lo", 64'(gLo), 64'(12));
      check("after_flush_hi", 64'(gHi), 64'(0));
      mHi = 0; mLo = 12;

      // Result held in DONE while E is stalled, committed once it retires.
      begin
         int guard;
         guard = 0; low = 0;
         @(posedge clk); #1;
         bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 32'd100; bus.b = 32'd7;
         #1;
         while (bus.done == 1'b0 && guard < 200) begin
            low++; guard++;
            @(posedge clk); #2;
         end
         if (guard >= 200) check("timeout_stall", 64'(guard), 64'(0));
         check("stall_low", 64'(low), 64'(c_DIV_LOW));
         bus.e_stall = 1'b1;
         for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d_done", k), 64'(bus.done), 64'(1));
            check($sformatf("stall%0d_hilo", k), {bus.hi, bus.lo}, {mHi, mLo});
            @(posedge clk); #1;
         end
         bus.e_stall = 1'b0;
         #1 check("stall_release_done", 64'(bus.done), 64'(1));
         @(posedge clk); #1;
         bus.start = 1'b0; bus.op = MDU_NONE;
         #1 check("stall_commit", {bus.hi, bus.lo}, {32'd2, 32'd14});
         mHi = 2; mLo = 14;
      end

      // Reset in the middle of a divide.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = MDU_DIV; bus.a = 32'd77; bus.b = 32'd5;
      repeat (5) @(posedge clk);
      #1;
      bus.start = 1'b0; bus.op = MDU_NONE; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("midreset_done", 64'(bus.done), 64'(1));
      check("midreset_hilo", {bus.hi, bus.lo}, 64'(0));
      mHi = 0; mLo = 0;

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         mdu_op_t     rop;
         logic [31:0] ra, rb;
         rop = mdu_op_t'($urandom_range(1, 6));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = $urandom_range(1, 15);
            3: ra = 32'hFFFF_FFFF;
            default: ;
         endcase
         modelApply(rop, ra, rb);
         runOp(rop, ra, rb, low, gHi, gLo);
         check($sformatf("rnd%0d_low op=%0d", i, rop), 64'(low), 64'(expLow(rop)));
         check($sformatf("rnd%0d_hi a=%0h b=%0h", i, ra, rb), 64'(gHi), 64'(mHi));
         check($sformatf("rnd%0d_lo a=%0h b=%0h", i, ra, rb), 64'(gLo), 64'(mLo));
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule

`default_nettype wire
